// File: rtl/serial_add_seq.sv
// Bit-serial add sequencer: streams two operands LSB-first through an
// external full_adder cell and collects the WIDTH-bit sum plus carry-out.
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             X,
    output logic             Y,
    output logic             Cprev,
    input  logic             RES,
    input  logic             Cnext,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             BUSY,
    output logic             DONE
);

    // cnt must reach WIDTH-1 without wrapping, also for WIDTH=1
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic [CW-1:0]    cnt;
    logic             unused_lsb;

    // Sum bits enter at the top; after WIDTH shifts bit 0 holds the LSB
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_nxt = RES;
        end else begin : g_wn
            assign s_nxt = {RES, s_sh[WIDTH-1:1]};
        end
    endgenerate

    // The oldest sum bit is shifted out and never needed
    assign unused_lsb = s_sh[0];

    // Drive the adder cell and status straight from registers
    assign X     = a_sh[0];
    assign Y     = b_sh[0];
    assign Cprev = carry;
    assign SUM   = sum_r;
    assign COUT  = cout_r;
    assign BUSY  = (state == SHIFT);
    assign DONE  = (state == FIN);

    // Sequencer: load, shift one bit per cycle, publish, pulse DONE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= CIN;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_sh  <= s_nxt;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= Cnext;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_r  <= s_nxt;
                        cout_r <= Cnext;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: WIDTH=4 and WIDTH=3 instances, each looped
// through a behavioural full adder, checked every cycle against a model.
module tb_serial_add_seq;

    logic       CLK;
    logic       RST_N;

    logic       st4, ci4, X4, Y4, Cp4, R4, Cn4, COUT4, BUSY4, DONE4;
    logic [3:0] a4, b4, SUM4;
    logic       st3, ci3, X3, Y3, Cp3, R3, Cn3, COUT3, BUSY3, DONE3;
    logic [2:0] a3, b3, SUM3;

    int checks;
    int failures;

    assign R4  = X4 ^ Y4 ^ Cp4;
    assign Cn4 = (X4 & Y4) | (X4 & Cp4) | (Y4 & Cp4);
    assign R3  = X3 ^ Y3 ^ Cp3;
    assign Cn3 = (X3 & Y3) | (X3 & Cp3) | (Y3 & Cp3);

    serial_add_seq #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .START(st4),
        .A(a4), .B(b4), .CIN(ci4),
        .X(X4), .Y(Y4), .Cprev(Cp4),
        .RES(R4), .Cnext(Cn4),
        .SUM(SUM4), .COUT(COUT4), .BUSY(BUSY4), .DONE(DONE4)
    );

    serial_add_seq #(.WIDTH(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .START(st3),
        .A(a3), .B(b3), .CIN(ci3),
        .X(X3), .Y(Y3), .Cprev(Cp3),
        .RES(R3), .Cnext(Cn3),
        .SUM(SUM3), .COUT(COUT3), .BUSY(BUSY3), .DONE(DONE3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Transaction-level model: an accepted START at edge t0 means bit k
    // is presented after edge t0+k, the result lands at edge t0+W and the
    // unit accepts again from edge t0+W+2.
    int n;
    bit act [2];
    int t0  [2];
    int ea  [2];
    int eb  [2];
    int ec  [2];
    int es  [2];
    int eco [2];

    always @(posedge CLK or negedge RST_N) begin
        int w;
        int tot;
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 1'b0;
                es[i]  = 0;
                eco[i] = 0;
            end
        end else begin
            n++;
            for (int i = 0; i < 2; i++) begin
                w = (i == 0) ? 4 : 3;
                if (act[i]) begin
                    if (n - t0[i] == w) begin
                        tot    = ea[i] + eb[i] + ec[i];
                        es[i]  = tot % (1 << w);
                        eco[i] = (tot >> w) & 1;
                    end else if (n - t0[i] == w + 1) begin
                        act[i] = 1'b0;
                    end
                end else if ((i == 0) ? st4 : st3) begin
                    act[i] = 1'b1;
                    t0[i]  = n;
                    ea[i]  = (i == 0) ? int'(a4) : int'(a3);
                    eb[i]  = (i == 0) ? int'(b4) : int'(b3);
                    ec[i]  = (i == 0) ? int'(ci4) : int'(ci3);
                end
            end
        end
    end

    // Expected pin values after the latest edge, from the model state
    int xb [2], xx [2], xy [2], xc [2], xd [2];

    always @(negedge CLK) begin
        int w;
        int k;
        int m;
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? 4 : 3;
            k = n - t0[i];
            xb[i] = (act[i] && k < w) ? 1 : 0;
            xd[i] = (act[i] && k == w) ? 1 : 0;
            if (xb[i] != 0) begin
                m     = (1 << k) - 1;
                xx[i] = (ea[i] >> k) & 1;
                xy[i] = (eb[i] >> k) & 1;
                xc[i] = (((ea[i] & m) + (eb[i] & m) + ec[i]) >> k) & 1;
            end else begin
                xx[i] = 0;
                xy[i] = 0;
                xc[i] = eco[i];
            end
        end
        chk("w4_busy", int'(BUSY4), xb[0]);
        chk("w4_done", int'(DONE4), xd[0]);
        chk("w4_x", int'(X4), xx[0]);
        chk("w4_y", int'(Y4), xy[0]);
        chk("w4_cprev", int'(Cp4), xc[0]);
        chk("w4_sum", int'(SUM4), es[0]);
        chk("w4_cout", int'(COUT4), eco[0]);
        chk("w3_busy", int'(BUSY3), xb[1]);
        chk("w3_done", int'(DONE3), xd[1]);
        chk("w3_x", int'(X3), xx[1]);
        chk("w3_y", int'(Y3), xy[1]);
        chk("w3_cprev", int'(Cp3), xc[1]);
        chk("w3_sum", int'(SUM3), es[1]);
        chk("w3_cout", int'(COUT3), eco[1]);
    end

    // One START pulse on instance i; collects X/Y while BUSY and the result
    task automatic op(input int i, input int a, input int b, input int c,
                      input bit chg, output int gs, output int gc,
                      output int xs, output int ys);
        int k;
        bit seen;
        @(negedge CLK);
        #1;
        if (i == 0) begin
            st4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; ci4 = c[0];
        end else begin
            st3 = 1'b1; a3 = a[2:0]; b3 = b[2:0]; ci3 = c[0];
        end
        @(posedge CLK);
        #1;
        st4 = 1'b0;
        st3 = 1'b0;
        if (chg) begin
            a4 = 4'hf; b4 = 4'hf; a3 = 3'h7; b3 = 3'h7;
        end
        xs = 0; ys = 0; k = 0; seen = 1'b0; gs = -1; gc = -1;
        for (int j = 0; j < 12 && !seen; j++) begin
            @(negedge CLK);
            if (i == 0) begin
                if (BUSY4) begin
                    xs |= int'(X4) << k; ys |= int'(Y4) << k; k++;
                end
                if (DONE4) begin
                    seen = 1'b1; gs = int'(SUM4); gc = int'(COUT4);
                end
            end else begin
                if (BUSY3) begin
                    xs |= int'(X3) << k; ys |= int'(Y3) << k; k++;
                end
                if (DONE3) begin
                    seen = 1'b1; gs = int'(SUM3); gc = int'(COUT3);
                end
            end
        end
        chk("done_within_bound", int'(seen), 1);
        chk("busy_cycles", k, (i == 0) ? 4 : 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gs, gc, xs, ys, nd, nb;
        checks = 0; failures = 0; n = 0;
        RST_N = 1'b0;
        st4 = 0; a4 = 0; b4 = 0; ci4 = 0;
        st3 = 0; a3 = 0; b3 = 0; ci3 = 0;
        #3;
        chk("rst_sum", int'(SUM4), 0);
        chk("rst_cout", int'(COUT4), 0);
        chk("rst_busy", int'(BUSY4), 0);
        chk("rst_done", int'(DONE4), 0);
        chk("rst_xyc", int'({X4, Y4, Cp4}), 0);
        chk("rst_w3", int'({SUM3, COUT3, BUSY3, DONE3}), 0);
        #9;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        op(0, 5, 3, 0, 1'b0, gs, gc, xs, ys);
        chk("5+3_sum", gs, 8);
        chk("5+3_cout", gc, 0);
        chk("5+3_xseq", xs, 4'b0101);
        chk("5+3_yseq", ys, 4'b0011);
        op(0, 15, 1, 0, 1'b0, gs, gc, xs, ys);
        chk("15+1_sum", gs, 0);
        chk("15+1_cout", gc, 1);
        op(0, 7, 8, 1, 1'b0, gs, gc, xs, ys);
        chk("7+8+1_sum", gs, 0);
        chk("7+8+1_cout", gc, 1);
        op(0, 0, 0, 1, 1'b0, gs, gc, xs, ys);
        chk("0+0+1_sum", gs, 1);
        chk("0+0+1_cout", gc, 0);

        @(negedge CLK);
        #1;
        st4 = 1'b1; a4 = 4'd2; b4 = 4'd2; ci4 = 1'b0;
        nd = 0; nb = 0;
        for (int j = 0; j < 18; j++) begin
            @(negedge CLK);
            if (DONE4) begin
                nd++;
                chk("held_sum", int'(SUM4), 4);
            end
            if (BUSY4) nb++;
        end
        #1;
        st4 = 1'b0;
        chk("held_done_count", nd, 3);
        chk("held_busy_count", nb, 12);
        repeat (3) @(negedge CLK);

        op(0, 5, 3, 0, 1'b1, gs, gc, xs, ys);
        chk("late_change_sum", gs, 8);
        chk("late_change_cout", gc, 0);
        repeat (2) @(negedge CLK);

        #1;
        st4 = 1'b1; a4 = 4'd15; b4 = 4'd15; ci4 = 1'b0;
        @(posedge CLK);
        #1;
        st4 = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort_sum", int'(SUM4), 0);
        chk("abort_cout", int'(COUT4), 0);
        chk("abort_busy", int'(BUSY4), 0);
        chk("abort_done", int'(DONE4), 0);
        chk("abort_xyc", int'({X4, Y4, Cp4}), 0);
        nd = 0;
        repeat (3) @(negedge CLK) if (DONE4) nd++;
        #1;
        RST_N = 1'b1;
        repeat (6) @(negedge CLK) if (DONE4) nd++;
        chk("abort_no_done", nd, 0);
        op(0, 1, 1, 0, 1'b0, gs, gc, xs, ys);
        chk("post_rst_sum", gs, 2);
        chk("post_rst_cout", gc, 0);

        for (int j = 0; j < 400; j++) begin
            @(negedge CLK);
            #1;
            st4 = ($urandom % 4) == 0;
            a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
            st3 = ($urandom % 3) == 0;
            a3 = 3'($urandom); b3 = 3'($urandom); ci3 = 1'($urandom);
        end
        @(negedge CLK);
        #1;
        st4 = 1'b0; st3 = 1'b0;
        repeat (8) @(negedge CLK);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    op(1, a, b, c, 1'b0, gs, gc, xs, ys);
                    chk("sweep_w3", gc * 8 + gs, a + b + c);
                end
            end
        end
        repeat (3) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
